// File: rtl/gt5232_chip.sv
// gt5232 top: I2C-compatible 256 x 8 EEPROM-style slave with split SDA lines.
// Bus inputs are oversampled in the clk domain; all state changes on clk rising edge.
module gt5232_chip #(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda_m2s,
    output logic sda_s2m
);

    typedef enum logic [3:0] {
        StIdle,
        StDevAddr,
        StAckDev,
        StWordAddr,
        StAckWord,
        StWrData,
        StAckWr,
        StRdData,
        StRdAck,
        StWaitStop
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_hist_q, sda_hist_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       sda_out_q, sda_out_d;
    logic       mem_we;
    logic [7:0] rd_byte;
    logic [7:0] mem_q [256];

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_m2s};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
    assign rd_byte   = mem_q[ptr_q];
    assign sda_s2m   = sda_out_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        sda_out_d = sda_out_q;
        mem_we    = 1'b0;

        // Bus conditions override any bit activity seen in the same cycle.
        if (start_det) begin
            state_d   = StDevAddr;
            bit_cnt_d = 4'd0;
            sda_out_d = 1'b1;
        end else if (stop_det) begin
            state_d   = StIdle;
            sda_out_d = 1'b1;
        end else begin
            case (state_q)
                StIdle, StWaitStop: ;
                StDevAddr, StWordAddr, StWrData: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        sda_out_d = 1'b0;
                        if (state_q == StDevAddr) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                rw_d    = shift_q[0];
                                state_d = StAckDev;
                            end else begin
                                sda_out_d = 1'b1;
                                state_d   = StWaitStop;
                            end
                        end else if (state_q == StWordAddr) begin
                            ptr_d   = shift_q;
                            state_d = StAckWord;
                        end else begin
                            mem_we  = 1'b1;
                            ptr_d   = ptr_q + 8'd1;
                            state_d = StAckWr;
                        end
                    end
                end
                StAckDev: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            sda_out_d = rd_byte[7];
                            shift_d   = {rd_byte[6:0], 1'b1};
                            bit_cnt_d = 4'd1;
                            state_d   = StRdData;
                        end else begin
                            sda_out_d = 1'b1;
                            state_d   = StWordAddr;
                        end
                    end
                end
                StAckWord, StAckWr: begin
                    if (scl_fall) begin
                        sda_out_d = 1'b1;
                        state_d   = StWrData;
                    end
                end
                StRdData: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_out_d = rd_byte[7];
                            shift_d   = {rd_byte[6:0], 1'b1};
                            bit_cnt_d = 4'd1;
                        end else if (bit_cnt_q == 4'd8) begin
                            sda_out_d = 1'b1;
                            bit_cnt_d = 4'd0;
                            state_d   = StRdAck;
                        end else begin
                            sda_out_d = shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b1};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        ptr_d     = ptr_q + 8'd1;
                        bit_cnt_d = 4'd0;
                        state_d   = sda_s ? StWaitStop : StRdData;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            ptr_q     <= 8'd0;
            rw_q      <= 1'b0;
            sda_out_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            sda_out_q <= sda_out_d;
        end
    end

    // Storage is never cleared; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[ptr_q] <= shift_q;
        end
    end

endmodule

// File: tb/tb_gt5232_chip.sv
// Directed bench for gt5232_chip: drives master-side SCL/SDA and checks ACKs,
// read data and memory contents against hand-computed values.
module tb_gt5232_chip;

    logic clk = 1'b0;
    logic reset;
    logic scl;
    logic sda_m2s;
    logic sda_s2m;

    int errors = 0;
    int checks = 0;
    logic       low_seen;
    logic       ack;
    logic [7:0] d;

    gt5232_chip #(
        .DEV_ADDR   (7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .scl    (scl),
        .sda_m2s(sda_m2s),
        .sda_s2m(sda_s2m)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One SCL period; returns sda_s2m sampled mid-high.
    task automatic bus_bit(input logic b, output logic s);
        sda_m2s = b;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(4);
        s = sda_s2m;
        if (!s) low_seen = 1'b1;
        wait_clk(4);
        scl = 1'b0;
        wait_clk(4);
    endtask

    task automatic start_cond();
        sda_m2s = 1'b1;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(8);
        sda_m2s = 1'b0;
        wait_clk(8);
        scl = 1'b0;
        wait_clk(4);
    endtask

    task automatic stop_cond();
        sda_m2s = 1'b0;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(8);
        sda_m2s = 1'b1;
        wait_clk(8);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, a);
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            v[i] = s;
        end
        bus_bit(master_ack, s);
    endtask

    initial begin
        scl     = 1'b1;
        sda_m2s = 1'b1;
        reset   = 1'b1;
        wait_clk(5);
        check("reset_sda", sda_s2m, 1'b1);
        reset = 1'b0;
        wait_clk(1);
        check("reset_ptr", dut.ptr_q, 8'h00);
        low_seen = 1'b0;
        repeat (100) begin
            wait_clk(1);
            if (!sda_s2m) low_seen = 1'b1;
        end
        check("idle_sda", low_seen, 1'b0);

        // Sequential write of two bytes at 0x10
        start_cond();
        send_byte(8'hA0, ack); check("wr_ack_dev", ack, 1'b0);
        send_byte(8'h10, ack); check("wr_ack_word", ack, 1'b0);
        send_byte(8'h5A, ack); check("wr_ack_d0", ack, 1'b0);
        send_byte(8'hC3, ack); check("wr_ack_d1", ack, 1'b0);
        stop_cond();
        check("mem_10", dut.mem_q[8'h10], 8'h5A);
        check("mem_11", dut.mem_q[8'h11], 8'hC3);

        // Random read via repeated START
        start_cond();
        send_byte(8'hA0, ack); check("rr_ack_dev", ack, 1'b0);
        send_byte(8'h10, ack); check("rr_ack_word", ack, 1'b0);
        start_cond();
        send_byte(8'hA1, ack); check("rr_ack_rd", ack, 1'b0);
        recv_byte(1'b0, d); check("rr_byte0", d, 8'h5A);
        recv_byte(1'b1, d); check("rr_byte1", d, 8'hC3);
        wait_clk(4);
        check("rr_nack_release", sda_s2m, 1'b1);
        stop_cond();

        // Seed 0x00/0x01, then wrap write from 0xFF
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h00, ack);
        send_byte(8'h77, ack);
        send_byte(8'h66, ack); check("seed_ack", ack, 1'b0);
        stop_cond();
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'hFF, ack);
        send_byte(8'h11, ack);
        send_byte(8'h22, ack); check("wrap_ack", ack, 1'b0);
        stop_cond();
        check("mem_ff", dut.mem_q[8'hFF], 8'h11);
        check("mem_00", dut.mem_q[8'h00], 8'h22);
        check("wrap_ptr", dut.ptr_q, 8'h01);
        start_cond();
        send_byte(8'hA1, ack); check("cur_ack", ack, 1'b0);
        recv_byte(1'b1, d); check("cur_read", d, 8'h66);
        stop_cond();

        // Wrong device address: no ACK, later bytes ignored
        start_cond();
        low_seen = 1'b0;
        send_byte(8'hA2, ack);
        check("bad_nack", low_seen, 1'b0);
        send_byte(8'h10, ack);
        send_byte(8'h99, ack);
        check("bad_ignored", low_seen, 1'b0);
        stop_cond();
        check("bad_mem_10", dut.mem_q[8'h10], 8'h5A);
        check("bad_ptr", dut.ptr_q, 8'h02);

        // STOP after 4 data bits discards the partial byte
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h10, ack);
        bus_bit(1'b1, ack);
        bus_bit(1'b1, ack);
        bus_bit(1'b1, ack);
        bus_bit(1'b0, ack);
        stop_cond();
        check("part_mem_10", dut.mem_q[8'h10], 8'h5A);
        check("part_ptr", dut.ptr_q, 8'h10);
        check("part_sda", sda_s2m, 1'b1);
        start_cond();
        send_byte(8'hA1, ack);
        recv_byte(1'b1, d); check("part_read", d, 8'h5A);
        stop_cond();

        // Reset while a read byte is on the bus
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h10, ack);
        start_cond();
        send_byte(8'hA1, ack);
        sda_m2s = 1'b1;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(4);
        check("rst_rd_bit7", sda_s2m, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rd_sda", sda_s2m, 1'b1);
        check("rst_rd_ptr", dut.ptr_q, 8'h00);
        reset = 1'b0;
        wait_clk(4);
        scl = 1'b0;
        wait_clk(4);
        stop_cond();
        start_cond();
        send_byte(8'hA1, ack);
        recv_byte(1'b1, d); check("post_rst_read", d, 8'h22);
        stop_cond();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
